alu_exec_unit: RTL

//  Multi-cycle ALU datapath that consumes the 4-bit aluop code produced by the ALU controller.

---
 rtl/alu_exec_unit.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//   EX-stage execution unit driven by the 4-bit aluop from the ALU controller.
//   One operation per valid/ready transaction. Shifts run on a serial
//   one-bit-per-cycle shifter. Every other operation, including an illegal
//   aluop, finishes on the accept edge. Result and flags are registered and
//   are held until the consumer takes them.
// ---------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  // aluop encodings produced by the ALU controller
  localparam logic [3:0] OP_SLL  = 4'd0;
  localparam logic [3:0] OP_SRA  = 4'd1;
  localparam logic [3:0] OP_SRL  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_NOR  = 4'd10;
  localparam logic [3:0] OP_SLT  = 4'd11;
  localparam logic [3:0] OP_SLTU = 4'd12;

  localparam logic [SHW-1:0]   CNT_ZERO  = {SHW{1'b0}};
  localparam logic [SHW-1:0]   CNT_ONE   = {{(SHW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] DATA_ONES = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SH_LL = 2'd0,
    SH_RA = 2'd1,
    SH_RL = 2'd2
  } shkind_t;

  // ---------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------

  // Zero detect on a full-width value.
  function automatic logic is_zero(input logic [WIDTH-1:0] v);
    logic z;
    z = (v == DATA_ZERO);
    return z;
  endfunction

  // One step of the serial shifter. SRA refills with the current MSB. The
  // MSB never changes during a right-arithmetic shift, so this is always the
  // sign bit of the original operand.
  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v,
                                                 input shkind_t          k);
    logic [WIDTH-1:0] r;
    case (k)
      SH_LL:   r = {v[WIDTH-2:0], 1'b0};
      SH_RA:   r = {v[WIDTH-1], v[WIDTH-1:1]};
      SH_RL:   r = {1'b0, v[WIDTH-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  // Signed overflow of an add: both operands have the same sign, and the
  // result sign differs from them.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    logic o;
    o = (sa == sb) && (sr != sa);
    return o;
  endfunction

  // Signed overflow of a subtract: the operands have different signs, and
  // the result sign differs from the minuend.
  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    logic o;
    o = (sa != sb) && (sr != sa);
    return o;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t           state_q,    state_d;
  shkind_t          shkind_q,   shkind_d;
  logic [WIDTH-1:0] work_q,     work_d;
  logic [SHW-1:0]   count_q,    count_d;
  logic [WIDTH-1:0] result_q,   result_d;
  logic             zero_q,     zero_d;
  logic             overflow_q, overflow_d;
  logic             illegal_q,  illegal_d;
  logic             out_valid_q, out_valid_d;

  // ---------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic             lt_s;
  logic             ltu_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_ovf_s;
  logic             alu_ill_s;
  logic             is_shift_s;
  shkind_t          shkind_s;
  logic [SHW-1:0]   shamt_s;
  logic [WIDTH-1:0] work_next_s;
  logic             accept_s;

  assign sum_s   = a + b;
  assign diff_s  = a - b;
  assign lt_s    = ($signed(a) < $signed(b));
  assign ltu_s   = (a < b);
  assign shamt_s = a[SHW-1:0];

  // The unit takes a new operation only while idle and out of reset.
  assign in_ready = (state_q == ST_IDLE) && !rst;
  assign accept_s = in_valid && in_ready;

  // One step of the serial shifter applied to the working register.
  assign work_next_s = shift_one(work_q, shkind_q);

  // Decode aluop into a single-cycle result, overflow, illegal, and shift kind.
  always_comb begin
    alu_res_s  = DATA_ZERO;
    alu_ovf_s  = 1'b0;
    alu_ill_s  = 1'b0;
    is_shift_s = 1'b0;
    shkind_s   = SH_LL;
    case (aluop)
      OP_SLL: begin
        is_shift_s = 1'b1;
        shkind_s   = SH_LL;
      end
      OP_SRA: begin
        is_shift_s = 1'b1;
        shkind_s   = SH_RA;
      end
      OP_SRL: begin
        is_shift_s = 1'b1;
        shkind_s   = SH_RL;
      end
      OP_ADD: begin
        alu_res_s = sum_s;
        alu_ovf_s = add_ovf(a[WIDTH-1], b[WIDTH-1], sum_s[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_s = diff_s;
        alu_ovf_s = sub_ovf(a[WIDTH-1], b[WIDTH-1], diff_s[WIDTH-1]);
      end
      OP_AND:  alu_res_s = a & b;
      OP_OR:   alu_res_s = a | b;
      OP_XOR:  alu_res_s = a ^ b;
      OP_NOR:  alu_res_s = ~(a | b) & DATA_ONES;
      OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, lt_s};
      OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, ltu_s};
      default: begin
        alu_res_s = DATA_ZERO;
        alu_ill_s = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------

  // Next-state, shifter, and result/flag update logic.
  always_comb begin
    state_d     = state_q;
    shkind_d    = shkind_q;
    work_d      = work_q;
    count_d     = count_q;
    result_d    = result_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;
    illegal_d   = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (is_shift_s) begin
            shkind_d = shkind_s;
            work_d   = b;
            count_d  = shamt_s;
            if (shamt_s == CNT_ZERO) begin
              // A zero shift amount completes at once with b unchanged.
              result_d   = b;
              zero_d     = is_zero(b);
              overflow_d = 1'b0;
              illegal_d  = 1'b0;
              state_d    = ST_DONE;
            end else begin
              state_d = ST_SHIFT;
            end
          end else begin
            result_d   = alu_res_s;
            zero_d     = is_zero(alu_res_s);
            overflow_d = alu_ovf_s;
            illegal_d  = alu_ill_s;
            state_d    = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        work_d  = work_next_s;
        count_d = count_q - CNT_ONE;
        if (count_q == CNT_ONE) begin
          result_d   = work_next_s;
          zero_d     = is_zero(work_next_s);
          overflow_d = 1'b0;
          illegal_d  = 1'b0;
          state_d    = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    out_valid_d = (state_d == ST_DONE);
  end

  // Registers. A synchronous reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shkind_q    <= SH_LL;
      work_q      <= DATA_ZERO;
      count_q     <= CNT_ZERO;
      result_q    <= DATA_ZERO;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shkind_q    <= shkind_d;
      work_q      <= work_d;
      count_q     <= count_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
  assign illegal   = illegal_q;

endmodule
